memory_responder: RTL and testbench

Word-organised memory serving the core's unified memory port. Sits on the far side of the data path's `read_memory_*` / `write_memory_*` signals and completes each READ or WRITE after a configurable number of wait states. A `memory_ready` pulse tells the controller when read data is valid or a write has committed. It is the initiator's counterpart: it decodes addresses, applies the 32-bit bit-mask merge and returns load words.

---
 rtl/controller_pkg.sv | 13 +
 rtl/memory_pkg.sv | 24 ++
 rtl/memory_responder_if.sv | 54 +++++
 rtl/memory_array.sv | 45 ++++
 rtl/memory_responder.sv | 165 ++++++++++++++++
 tb/tb_memory_responder.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/controller_pkg.sv
// controller_pkg
// Shared definitions for the core's memory controller. The memory
// responder reuses the command encoding from here so both sides of the
// unified memory port agree on READ/WRITE.
// No ports (package only).
package controller_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } memory_command_t;

endpackage

// File: rtl/memory_pkg.sv
// memory_pkg
// Definitions private to the memory responder: the responder FSM state
// encoding, the wait-state counter width and the default array depth.
// Also a helper that turns a byte address into a word offset from base.
// No ports (package only).
package memory_pkg;

  localparam int unsigned WAIT_COUNT_WIDTH    = 4;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } responder_state_t;

  // Byte address to word offset relative to base; bits [1:0] drop out
  // because alignment is the initiator's responsibility.
  function automatic logic [31:0] word_offset(input logic [31:0] address,
                                              input logic [31:0] base);
    return (address - base) >> 2;
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// memory_responder_if
// Bundles the unified memory port between the core (master) and the
// memory responder (slave).
//   memory_request        master -> slave  transaction valid
//   memory_command        master -> slave  READ / WRITE
//   read_memory_address   master -> slave  byte address for READ
//   write_memory_address  master -> slave  byte address for WRITE
//   write_memory_data     master -> slave  lane-aligned store data
//   write_memory_mask     master -> slave  per-bit write enable
//   read_memory_data      slave -> master  load word
//   memory_ready          slave -> master  one-cycle completion pulse
//   access_fault          slave -> master  out-of-range access (only when
//                                          MEMORY_RESPONDER_BOUNDS_CHECK_EN
//                                          is defined)
interface memory_responder_if;
  import controller_pkg::*;

  logic            memory_request;
  memory_command_t memory_command;
  logic [31:0]     read_memory_address;
  logic [31:0]     write_memory_address;
  logic [31:0]     write_memory_data;
  logic [31:0]     write_memory_mask;
  logic [31:0]     read_memory_data;
  logic            memory_ready;
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
  logic            access_fault;

  modport master (
    output memory_request, memory_command, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    input  read_memory_data, memory_ready, access_fault
  );

  modport slave (
    input  memory_request, memory_command, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    output read_memory_data, memory_ready, access_fault
  );
`else
  modport master (
    output memory_request, memory_command, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    input  read_memory_data, memory_ready
  );

  modport slave (
    input  memory_request, memory_command, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    output read_memory_data, memory_ready
  );
`endif

endinterface

// File: rtl/memory_array.sv
// memory_array
// Single-port word RAM with a synchronous bit-masked write and a
// registered read. Only the read register is reset; contents are not.
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-low; clears the read register
//   enable      in   perform an access on this edge
//   write_en    in   1 = masked write, 0 = read into read_data
//   in_range    in   0 suppresses a write and makes a read return 0
//   index       in   word index
//   write_data  in   store data
//   write_mask  in   per-bit write enable
//   read_data   out  registered load word, held until the next read
module memory_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   write_en,
  input  logic                   in_range,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [31:0]            write_data,
  input  logic [31:0]            write_mask,
  output logic [31:0]            read_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (enable && write_en && in_range) begin
      mem[index] <= (mem[index] & ~write_mask) | (write_data & write_mask);
    end
  end

  // A write leaves the read register alone; an out-of-range read loads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
    end else if (enable && !write_en) begin
      read_data <= in_range ? mem[index] : '0;
    end
  end

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Word-organised memory behind the core's unified memory port. Accepts a
// READ or WRITE in IDLE, waits WAIT_STATES cycles, performs one access to
// memory_array, then pulses memory_ready for one cycle in DONE.
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-low
//   bus    slave modport of memory_responder_if (request/command/address/
//          data/mask in; read data, ready and optional fault out)
// Optional feature: MEMORY_RESPONDER_BOUNDS_CHECK_EN adds access_fault and
// suppresses out-of-range accesses; without it the index wraps.
module memory_responder
  import memory_pkg::*;
  import controller_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int unsigned WAIT_STATES  = 0
) (
  input logic               clk,
  input logic               reset,
  memory_responder_if.slave bus
);

  localparam int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS);

  responder_state_t            state;
  responder_state_t            next_state;
  logic [WAIT_COUNT_WIDTH-1:0] wait_count;
  logic [WAIT_COUNT_WIDTH-1:0] next_wait_count;

  logic [31:0]                 live_address;
  logic [31:0]                 live_word;
  logic [INDEX_WIDTH-1:0]      live_index;
  logic                        live_in_range;

  memory_command_t             latched_command;
  logic [INDEX_WIDTH-1:0]      latched_index;
  logic [31:0]                 latched_data;
  logic [31:0]                 latched_mask;
  logic                        latched_in_range;

  logic                        access_enable;
  logic                        access_write;
  logic [INDEX_WIDTH-1:0]      access_index;
  logic [31:0]                 access_data;
  logic [31:0]                 access_mask;
  logic                        access_in_range;
  logic [31:0]                 read_word;

  assign live_address = (bus.memory_command == WRITE) ? bus.write_memory_address
                                                      : bus.read_memory_address;
  assign live_word    = word_offset(live_address, BASE_ADDRESS);
  assign live_index   = live_word[INDEX_WIDTH-1:0];

`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
  // Addresses below base would wrap to a huge offset, so test them apart.
  assign live_in_range = (live_address >= BASE_ADDRESS) &&
                         (live_word < DEPTH_WORDS);
`else
  // Upper offset bits are deliberately discarded: the index wraps.
  logic unused_word_bits;
  assign unused_word_bits = ^live_word;
  assign live_in_range    = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_count <= '0;
    end else begin
      state      <= next_state;
      wait_count <= next_wait_count;
    end
  end

  // With zero wait states the access happens on the accepting edge and
  // uses the live bus fields; otherwise it uses the latched copy.
  always_comb begin
    next_state      = state;
    next_wait_count = wait_count;
    access_enable   = 1'b0;
    access_write    = (latched_command == WRITE);
    access_index    = latched_index;
    access_data     = latched_data;
    access_mask     = latched_mask;
    access_in_range = latched_in_range;
    unique case (state)
      IDLE: begin
        if (bus.memory_request) begin
          if (WAIT_STATES == 0) begin
            access_enable   = 1'b1;
            access_write    = (bus.memory_command == WRITE);
            access_index    = live_index;
            access_data     = bus.write_memory_data;
            access_mask     = bus.write_memory_mask;
            access_in_range = live_in_range;
            next_state      = DONE;
          end else begin
            next_wait_count = WAIT_COUNT_WIDTH'(WAIT_STATES - 1);
            next_state      = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_count == '0) begin
          access_enable = 1'b1;
          next_state    = DONE;
        end else begin
          next_wait_count = wait_count - 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the request so inputs need not be consulted during WAIT.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.memory_request) begin
      latched_command  <= bus.memory_command;
      latched_index    <= live_index;
      latched_data     <= bus.write_memory_data;
      latched_mask     <= bus.write_memory_mask;
      latched_in_range <= live_in_range;
    end
  end

  memory_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .enable     (access_enable),
    .write_en   (access_write),
    .in_range   (access_in_range),
    .index      (access_index),
    .write_data (access_data),
    .write_mask (access_mask),
    .read_data  (read_word)
  );

  assign bus.read_memory_data = read_word;
  assign bus.memory_ready     = (state == DONE);

`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
  logic fault_pending;

  // Remembered at the access edge so the fault lines up with DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_pending <= 1'b0;
    end else if (access_enable) begin
      fault_pending <= !access_in_range;
    end
  end

  assign bus.access_fault = (state == DONE) && fault_pending;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Directed bench for memory_responder: one instance with zero wait states
// and one with three, each on its own interface and reset. Expected values
// are hand-computed constants. MEMORY_RESPONDER_BOUNDS_CHECK_EN selects
// the expected out-of-range behaviour.
module tb_memory_responder;
  import controller_pkg::*;
  import memory_pkg::*;

  logic clk;
  logic reset_fast;
  logic reset_slow;
  int   checks;
  int   errors;

  memory_responder_if bus0 ();
  memory_responder_if bus3 ();

  memory_responder #(
    .DEPTH_WORDS  (4096),
    .BASE_ADDRESS (32'h0),
    .WAIT_STATES  (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset_fast),
    .bus   (bus0)
  );

  memory_responder #(
    .DEPTH_WORDS  (4096),
    .BASE_ADDRESS (32'h0),
    .WAIT_STATES  (3)
  ) dut3 (
    .clk   (clk),
    .reset (reset_slow),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus_fast(input memory_command_t cmd,
                                     input logic [31:0] addr, data, mask);
    bus0.memory_command       = cmd;
    bus0.read_memory_address  = addr;
    bus0.write_memory_address = addr;
    bus0.write_memory_data    = data;
    bus0.write_memory_mask    = mask;
    bus0.memory_request       = 1'b1;
  endtask

  task automatic apply_stimulus_slow(input memory_command_t cmd,
                                     input logic [31:0] addr, data, mask);
    bus3.memory_command       = cmd;
    bus3.read_memory_address  = addr;
    bus3.write_memory_address = addr;
    bus3.write_memory_data    = data;
    bus3.write_memory_mask    = mask;
    bus3.memory_request       = 1'b1;
  endtask

  // Called at a negedge with dut0 idle: request in cycle 0, ready in cycle 1.
  task automatic run_fast(input string tag, input memory_command_t cmd,
                          input logic [31:0] addr, data, mask, expected);
    apply_stimulus_fast(cmd, addr, data, mask);
    @(negedge clk);
    check_output({tag, "_ready"}, 32'(bus0.memory_ready), 32'd1);
    check_output({tag, "_data"}, bus0.read_memory_data, expected);
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
    check_output({tag, "_fault"}, 32'(bus0.access_fault), 32'd0);
`endif
    bus0.memory_request = 1'b0;
    @(negedge clk);
    check_output({tag, "_after"}, 32'(bus0.memory_ready), 32'd0);
  endtask

  // Called at a negedge with dut3 idle: ready only in cycle 4, old data before.
  task automatic run_slow(input string tag, input memory_command_t cmd,
                          input logic [31:0] addr, data, mask, previous, expected);
    apply_stimulus_slow(cmd, addr, data, mask);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      check_output($sformatf("%s_ready_c%0d", tag, cyc), 32'(bus3.memory_ready),
                   (cyc == 4) ? 32'd1 : 32'd0);
      check_output($sformatf("%s_data_c%0d", tag, cyc), bus3.read_memory_data,
                   (cyc == 4) ? expected : previous);
    end
    bus3.memory_request = 1'b0;
    @(negedge clk);
    check_output({tag, "_after"}, 32'(bus3.memory_ready), 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_fast = 1'b0;
    reset_slow = 1'b0;
    bus0.memory_request = 1'b0;
    bus3.memory_request = 1'b0;
    bus0.memory_command = READ;
    bus3.memory_command = READ;
    bus0.read_memory_address  = '0;
    bus0.write_memory_address = '0;
    bus0.write_memory_data    = '0;
    bus0.write_memory_mask    = '0;
    bus3.read_memory_address  = '0;
    bus3.write_memory_address = '0;
    bus3.write_memory_data    = '0;
    bus3.write_memory_mask    = '0;
    $display("[TB] memory_responder directed sequence");

    // Reset values
    @(negedge clk);
    check_output("rst_ready0", 32'(bus0.memory_ready), 32'd0);
    check_output("rst_data0", bus0.read_memory_data, 32'd0);
    check_output("rst_ready3", 32'(bus3.memory_ready), 32'd0);
    check_output("rst_data3", bus3.read_memory_data, 32'd0);
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
    check_output("rst_fault0", 32'(bus0.access_fault), 32'd0);
`endif
    reset_fast = 1'b1;
    reset_slow = 1'b1;
    @(negedge clk);

    // Zero wait states: write then read back
    run_fast("wr100", WRITE, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0);
    run_fast("rd100", READ, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF);

    // Bit-mask merge and mask zero
    run_fast("wr40_full", WRITE, 32'h40, 32'h11223344, 32'hFFFFFFFF, 32'hDEADBEEF);
    run_fast("wr40_mask", WRITE, 32'h40, 32'h0000AA00, 32'h0000FF00, 32'hDEADBEEF);
    run_fast("rd40_merge", READ, 32'h40, 32'h0, 32'h0, 32'h1122AA44);
    run_fast("wr40_zero", WRITE, 32'h40, 32'hFFFFFFFF, 32'h0, 32'h1122AA44);
    run_fast("rd40_keep", READ, 32'h43, 32'h0, 32'h0, 32'h1122AA44);

    // Held request: ready in cycles 1 and 3, not 2
    apply_stimulus_fast(READ, 32'h100, 32'h0, 32'h0);
    @(negedge clk);
    check_output("b2b_ready_c1", 32'(bus0.memory_ready), 32'd1);
    check_output("b2b_data_c1", bus0.read_memory_data, 32'hDEADBEEF);
    @(negedge clk);
    check_output("b2b_ready_c2", 32'(bus0.memory_ready), 32'd0);
    @(negedge clk);
    check_output("b2b_ready_c3", 32'(bus0.memory_ready), 32'd1);
    check_output("b2b_data_c3", bus0.read_memory_data, 32'hDEADBEEF);
    bus0.memory_request = 1'b0;
    @(negedge clk);
    check_output("b2b_ready_c4", 32'(bus0.memory_ready), 32'd0);

    // Out-of-range read one past the last word
    run_fast("wr0", WRITE, 32'h0, 32'hA5A50001, 32'hFFFFFFFF, 32'hDEADBEEF);
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
    apply_stimulus_fast(READ, 32'h4000, 32'h0, 32'h0);
    @(negedge clk);
    check_output("oor_ready", 32'(bus0.memory_ready), 32'd1);
    check_output("oor_data", bus0.read_memory_data, 32'h0);
    check_output("oor_fault", 32'(bus0.access_fault), 32'd1);
    bus0.memory_request = 1'b0;
    @(negedge clk);
    check_output("oor_fault_clear", 32'(bus0.access_fault), 32'd0);
    run_fast("rd0_after_oor", READ, 32'h0, 32'h0, 32'h0, 32'hA5A50001);
`else
    run_fast("oor_wrap", READ, 32'h4000, 32'h0, 32'h0, 32'hA5A50001);
`endif

    // Three wait states: timing and held read data
    run_slow("s_wr204", WRITE, 32'h204, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h0);
    run_slow("s_rd204", READ, 32'h204, 32'h0, 32'h0, 32'h0, 32'h12345678);
    run_slow("s_wr200", WRITE, 32'h200, 32'hCAFEF00D, 32'hFFFFFFFF,
             32'h12345678, 32'h12345678);
    run_slow("s_rd200", READ, 32'h200, 32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D);
    run_slow("s_wr80", WRITE, 32'h80, 32'h5, 32'hFFFFFFFF, 32'hCAFEF00D, 32'hCAFEF00D);

    // Reset in cycle 2 of a write abandons it
    apply_stimulus_slow(WRITE, 32'h80, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    check_output("rstmid_ready_c1", 32'(bus3.memory_ready), 32'd0);
    @(negedge clk);
    reset_slow = 1'b0;
    bus3.memory_request = 1'b0;
    #1;
    check_output("rstmid_state", 32'(dut3.state), 32'(IDLE));
    check_output("rstmid_ready_c2", 32'(bus3.memory_ready), 32'd0);
    check_output("rstmid_data", bus3.read_memory_data, 32'h0);
    @(negedge clk);
    reset_slow = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check_output($sformatf("rstmid_quiet_%0d", cyc), 32'(bus3.memory_ready), 32'd0);
    end
    run_slow("s_rd80", READ, 32'h80, 32'h0, 32'h0, 32'h0, 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
